// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: single-outstanding req/ack data bus with byte lanes and load extension.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned accesses (err 01) instead of forcing natural alignment.
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_aluResult,
  input  logic [31:0] i_storeData,
  output logic        o_stall,
  output logic        o_valid,
  output logic [31:0] o_loadData,
  output logic [1:0]  o_err,
  output logic        o_busReq,
  output logic        o_busWe,
  output logic [31:0] o_busAddr,
  output logic [31:0] o_busWdata,
  output logic [3:0]  o_busByteEn,
  input  logic        i_busAck,
  input  logic [31:0] i_busRdata
);

  localparam int unsigned CNT_W = 16;
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]       addr_lo;
  logic [2:0]       f3_q;
  logic             we_q;
  logic [1:0]       err_pend;

  logic             accept;
  logic             f3_legal;
  logic [1:0]       eff_lo;
  logic [3:0]       byte_en;
  logic [31:0]      wdata;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      load_ext;
  logic [CNT_W-1:0] tmo_next;

  assign accept   = (state == IDLE) & i_valid & (i_memRead | i_memWrite);
  assign o_stall  = accept | ((state == REQ) & ~i_busAck) | (state == RESP);
  assign tmo_next = tmo_cnt + CNT_W'(1);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((i_funct3[1:0] == 2'b01) & i_aluResult[0]) |
                      ((i_funct3[1:0] == 2'b10) & (i_aluResult[1:0] != 2'b00));
`endif

  // Request decode: legality, lane offset, byte enables and replicated store data
  always_comb begin
    f3_legal = 1'b0;
    eff_lo   = i_aluResult[1:0];
    byte_en  = 4'b1111;
    wdata    = i_storeData;
    if (i_memWrite) begin
      f3_legal = (i_funct3 == 3'b000) | (i_funct3 == 3'b001) | (i_funct3 == 3'b010);
    end else begin
      f3_legal = (i_funct3 == 3'b000) | (i_funct3 == 3'b001) | (i_funct3 == 3'b010) |
                 (i_funct3 == 3'b100) | (i_funct3 == 3'b101);
    end
`ifndef LSU_MISALIGN_TRAP_EN
    if (i_funct3[1:0] == 2'b01) eff_lo = {i_aluResult[1], 1'b0};
    if (i_funct3[1:0] == 2'b10) eff_lo = 2'b00;
`endif
    case (i_funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << eff_lo;
        wdata   = {4{i_storeData[7:0]}};
      end
      2'b01: begin
        byte_en = 4'b0011 << eff_lo;
        wdata   = {2{i_storeData[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wdata   = i_storeData;
      end
    endcase
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    case (addr_lo)
      2'b00:   lane_b = i_busRdata[7:0];
      2'b01:   lane_b = i_busRdata[15:8];
      2'b10:   lane_b = i_busRdata[23:16];
      default: lane_b = i_busRdata[31:24];
    endcase
    lane_h = addr_lo[1] ? i_busRdata[31:16] : i_busRdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'h000000, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_ext = {16'h0000, lane_h};
      default: load_ext = i_busRdata;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      addr_lo     <= 2'b00;
      f3_q        <= 3'b000;
      we_q        <= 1'b0;
      err_pend    <= ERR_OK;
      o_valid     <= 1'b0;
      o_loadData  <= '0;
      o_err       <= ERR_OK;
      o_busReq    <= 1'b0;
      o_busWe     <= 1'b0;
      o_busAddr   <= '0;
      o_busWdata  <= '0;
      o_busByteEn <= 4'b0000;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_lo <= eff_lo;
            f3_q    <= i_funct3;
            we_q    <= i_memWrite;
            tmo_cnt <= '0;
            if (!f3_legal) begin
              state    <= RESP;
              err_pend <= ERR_ILLEGAL;
`ifdef LSU_MISALIGN_TRAP_EN
            end else if (misaligned) begin
              state    <= RESP;
              err_pend <= ERR_MISALIGN;
`endif
            end else begin
              state       <= REQ;
              o_busReq    <= 1'b1;
              o_busWe     <= i_memWrite;
              o_busAddr   <= {i_aluResult[31:2], 2'b00};
              o_busWdata  <= wdata;
              o_busByteEn <= byte_en;
            end
          end
        end
        REQ: begin
          if (i_busAck) begin
            state      <= IDLE;
            o_busReq   <= 1'b0;
            o_valid    <= 1'b1;
            o_err      <= ERR_OK;
            o_loadData <= we_q ? 32'h0 : load_ext;
          end else if (tmo_next == CNT_W'(TIMEOUT_CYCLES)) begin
            // Abandon the access; a late ack lands in RESP/IDLE and is ignored
            state    <= RESP;
            o_busReq <= 1'b0;
            err_pend <= ERR_TIMEOUT;
            tmo_cnt  <= '0;
          end else begin
            tmo_cnt <= tmo_next;
          end
        end
        RESP: begin
          state      <= IDLE;
          o_valid    <= 1'b1;
          o_err      <= err_pend;
          o_loadData <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table plus scoreboard of completions, with reset/timeout sequences.
module tb_mem_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        i_memRead;
  logic        i_memWrite;
  logic [2:0]  i_funct3;
  logic [31:0] i_aluResult;
  logic [31:0] i_storeData;
  logic        o_stall;
  logic        o_valid;
  logic [31:0] o_loadData;
  logic [1:0]  o_err;
  logic        o_busReq;
  logic        o_busWe;
  logic [31:0] o_busAddr;
  logic [31:0] o_busWdata;
  logic [3:0]  o_busByteEn;
  logic        i_busAck;
  logic [31:0] i_busRdata;

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_memRead(i_memRead),
    .i_memWrite(i_memWrite), .i_funct3(i_funct3), .i_aluResult(i_aluResult),
    .i_storeData(i_storeData), .o_stall(o_stall), .o_valid(o_valid),
    .o_loadData(o_loadData), .o_err(o_err), .o_busReq(o_busReq), .o_busWe(o_busWe),
    .o_busAddr(o_busAddr), .o_busWdata(o_busWdata), .o_busByteEn(o_busByteEn),
    .i_busAck(i_busAck), .i_busRdata(i_busRdata)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          ack_after;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
    logic [1:0]  exp_err;
    int          exp_reqc;
  } vec_t;

  typedef struct {
    logic [31:0] load;
    logic [1:0]  err;
  } resp_t;

  int    checks = 0;
  int    errors = 0;
  resp_t sb[$];
  vec_t  vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input int ack_after,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_load,
                              input logic [1:0] exp_err, input int exp_reqc);
    vec_t v;
    v.name = name; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.ack_after = ack_after; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_load = exp_load; v.exp_err = exp_err;
    v.exp_reqc = exp_reqc;
    return v;
  endfunction

  // Completion monitor: every o_valid pulse must match the oldest pending expectation
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got o_valid=1 expected no completion at %0t", $time);
      end else begin
        resp_t e;
        e = sb.pop_front();
        chk("sb_loadData", o_loadData, e.load);
        chk("sb_err", 32'(o_err), 32'(e.err));
      end
    end
  end

  // Drive one op, act as the bus, check bus fields, stall and valid timing
  task automatic run_op(input vec_t v);
    int  reqc;
    bit  done;
    resp_t r;
    @(negedge i_clk);
    i_valid = 1'b1; i_memRead = ~v.st; i_memWrite = v.st; i_funct3 = v.f3;
    i_aluResult = v.addr; i_storeData = v.sdata;
    r.load = v.exp_load; r.err = v.exp_err;
    sb.push_back(r);
    #1 chk({v.name, "_stall_accept"}, 32'(o_stall), 32'(1));
    reqc = 0;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge i_clk);
      i_busAck = 1'b0;
      if (o_busReq) begin
        if (reqc == 0) begin
          chk({v.name, "_busAddr"}, o_busAddr, v.exp_addr);
          chk({v.name, "_byteEn"}, 32'(o_busByteEn), 32'(v.exp_be));
          chk({v.name, "_busWe"}, 32'(o_busWe), 32'(v.st));
          if (v.st) chk({v.name, "_wdata"}, o_busWdata, v.exp_wdata);
        end
        reqc++;
        if (reqc == v.ack_after) begin
          i_busAck = 1'b1;
          i_busRdata = v.rdata;
        end
      end
      #1 done = !o_stall || !o_busReq;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: op still stalled after 60 cycles, expected completion", v.name);
    end
    chk({v.name, "_reqc"}, 32'(reqc), 32'(v.exp_reqc));
    @(negedge i_clk);
    i_valid = 1'b0; i_busAck = 1'b0;
    chk({v.name, "_valid_pulse"}, 32'(o_valid), 32'(1));
    @(negedge i_clk);
    chk({v.name, "_valid_once"}, 32'(o_valid), 32'(0));
  endtask

  initial begin
    vec_t tv;
    i_rst = 1'b1; i_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0; i_funct3 = 3'b000;
    i_aluResult = '0; i_storeData = '0; i_busAck = 1'b1; i_busRdata = 32'hFFFF_FFFF;

    vecs.push_back(mk("lw_100", 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 32'h100, 4'b1111, 0, 32'hDEADBEEF, 2'b00, 3));
    vecs.push_back(mk("lb_103", 0, 3'b000, 32'h103, 0, 32'h80112233, 1, 32'h100, 4'b1000, 0, 32'hFFFFFF80, 2'b00, 1));
    vecs.push_back(mk("lbu_103", 0, 3'b100, 32'h103, 0, 32'h80112233, 1, 32'h100, 4'b1000, 0, 32'h00000080, 2'b00, 1));
    vecs.push_back(mk("sh_202", 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 1, 32'h200, 4'b1100, 32'hABCDABCD, 0, 2'b00, 1));
    vecs.push_back(mk("lh_102", 0, 3'b001, 32'h102, 0, 32'h80011234, 2, 32'h100, 4'b1100, 0, 32'hFFFF8001, 2'b00, 2));
    vecs.push_back(mk("lhu_100", 0, 3'b101, 32'h100, 0, 32'h1234F00D, 1, 32'h100, 4'b0011, 0, 32'h0000F00D, 2'b00, 1));
    vecs.push_back(mk("sb_301", 1, 3'b000, 32'h301, 32'h1234565A, 0, 1, 32'h300, 4'b0010, 32'h5A5A5A5A, 0, 2'b00, 1));
    vecs.push_back(mk("sw_400", 1, 3'b010, 32'h400, 32'h12345678, 0, 2, 32'h400, 4'b1111, 32'h12345678, 0, 2'b00, 2));
    vecs.push_back(mk("lb_101", 0, 3'b000, 32'h101, 0, 32'h00007F00, 1, 32'h100, 4'b0010, 0, 32'h0000007F, 2'b00, 1));
    vecs.push_back(mk("ld_ill", 0, 3'b011, 32'h100, 0, 0, 1, 0, 0, 0, 0, 2'b11, 0));
    vecs.push_back(mk("st_ill", 1, 3'b100, 32'h100, 32'h55, 0, 1, 0, 0, 0, 0, 2'b11, 0));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("lw_101", 0, 3'b010, 32'h101, 0, 32'hCAFEF00D, 1, 0, 0, 0, 0, 2'b01, 0));
    vecs.push_back(mk("lh_103", 0, 3'b001, 32'h103, 0, 32'hABCD0000, 1, 0, 0, 0, 0, 2'b01, 0));
`else
    vecs.push_back(mk("lw_101", 0, 3'b010, 32'h101, 0, 32'hCAFEF00D, 1, 32'h100, 4'b1111, 0, 32'hCAFEF00D, 2'b00, 1));
    vecs.push_back(mk("lh_103", 0, 3'b001, 32'h103, 0, 32'hABCD0000, 1, 32'h100, 4'b1100, 0, 32'hFFFFABCD, 2'b00, 1));
`endif

    // Reset values, with a stray ack held across the reset edges
    repeat (2) @(negedge i_clk);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_busReq", 32'(o_busReq), 0);
    chk("rst_busWe", 32'(o_busWe), 0);
    chk("rst_byteEn", 32'(o_busByteEn), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_loadData", o_loadData, 0);
    chk("rst_busAddr", o_busAddr, 0);
    chk("rst_busWdata", o_busWdata, 0);
    i_rst = 1'b0; i_busAck = 1'b0;

    // Non-memory op is ignored
    @(negedge i_clk);
    i_valid = 1'b1;
    #1 chk("nonmem_stall", 32'(o_stall), 0);
    @(negedge i_clk);
    chk("nonmem_busReq", 32'(o_busReq), 0);
    i_valid = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Timeout, then a late ack must have no effect
    tv = mk("lw_tmo", 0, 3'b010, 32'h500, 0, 32'h11111111, 0, 32'h500, 4'b1111, 0, 0, 2'b10, 4);
    run_op(tv);
    i_busAck = 1'b1; i_busRdata = 32'h11111111;
    repeat (3) begin
      @(negedge i_clk);
      chk("late_ack_busReq", 32'(o_busReq), 0);
      chk("late_ack_err_hold", 32'(o_err), 32'(2'b10));
    end
    i_busAck = 1'b0;

    // Reset while REQ is outstanding abandons the access
    @(negedge i_clk);
    i_valid = 1'b1; i_memRead = 1'b1; i_memWrite = 1'b0; i_funct3 = 3'b010; i_aluResult = 32'h600;
    @(negedge i_clk);
    chk("rstreq_busReq_before", 32'(o_busReq), 1);
    i_rst = 1'b1; i_busAck = 1'b1; i_busRdata = 32'h22222222;
    @(negedge i_clk);
    chk("rstreq_busReq_after", 32'(o_busReq), 0);
    chk("rstreq_valid", 32'(o_valid), 0);
    i_rst = 1'b0; i_valid = 1'b0; i_busAck = 1'b0;
    repeat (2) @(negedge i_clk);

    tv = mk("lw_post_rst", 0, 3'b010, 32'h700, 0, 32'h0BADF00D, 1, 32'h700, 4'b1111, 0, 32'h0BADF00D, 2'b00, 1);
    run_op(tv);

    repeat (3) @(negedge i_clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
